// File: rtl/alu_iter_shifter.sv
// Iterative shift/rotate engine: applies one single-bit shift or rotate step per
// clock, with a valid/ready handshake on the operand side and on the result side.
module alu_iter_shifter #(
  parameter int unsigned W  = 21,
  parameter int unsigned SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [W-1:0]  data_in,
  input  logic [SW-1:0] amt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  data_out,
  output logic          carry_out,
  output logic          zero,
  output logic          err
);

  localparam logic [2:0] OP_LSR = 3'd0;
  localparam logic [2:0] OP_LSL = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_n;
  logic [W-1:0]  d_q, d_n;
  logic          c_q, c_n;
  logic          err_q, err_n;
  logic          zero_q, zero_n;
  logic [SW-1:0] cnt_q, cnt_n;
  logic [2:0]    op_q, op_n;
  logic          in_ready_q, in_ready_n;
  logic          out_valid_q, out_valid_n;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      d_q         <= '0;
      c_q         <= 1'b0;
      err_q       <= 1'b0;
      zero_q      <= 1'b0;
      cnt_q       <= '0;
      op_q        <= OP_LSR;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      d_q         <= d_n;
      c_q         <= c_n;
      err_q       <= err_n;
      zero_q      <= zero_n;
      cnt_q       <= cnt_n;
      op_q        <= op_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
    end
  end

  // Next-state, single-step datapath and registered handshake decode
  always_comb begin
    state_n = state_q;
    d_n     = d_q;
    c_n     = c_q;
    err_n   = err_q;
    zero_n  = zero_q;
    cnt_n   = cnt_q;
    op_n    = op_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_n  = op;
          d_n   = data_in;
          c_n   = 1'b0;
          err_n = 1'b0;
          if (op > OP_ROL) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else if (amt == '0) begin
            state_n = DONE;
          end else begin
            cnt_n   = amt;
            state_n = RUN;
          end
        end
      end

      RUN: begin
        case (op_q)
          OP_LSR: begin
            d_n = {1'b0, d_q[W-1:1]};
            c_n = d_q[0];
          end
          OP_LSL: begin
            d_n = {d_q[W-2:0], 1'b0};
            c_n = d_q[W-1];
          end
          OP_ASR: begin
            d_n = {d_q[W-1], d_q[W-1:1]};
            c_n = d_q[0];
          end
          OP_ROR: begin
            d_n = {d_q[0], d_q[W-1:1]};
            c_n = d_q[0];
          end
          OP_ROL: begin
            d_n = {d_q[W-2:0], d_q[W-1]};
            c_n = d_q[W-1];
          end
          default: begin
            d_n = d_q;
            c_n = c_q;
          end
        endcase
        cnt_n = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_n = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // zero tracks the data that will be presented while out_valid is high
    if (state_n == DONE) begin
      zero_n = (d_n == '0);
    end

    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = d_q;
  assign carry_out = c_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_iter_shifter.sv
// Randomized self-checking bench for alu_iter_shifter against a closed-form
// shift/rotate reference model.
module tb_alu_iter_shifter;

  localparam int unsigned W  = 21;
  localparam int unsigned SW = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  data_in;
  logic [SW-1:0] amt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  data_out;
  logic          carry_out;
  logic          zero;
  logic          err;

  int n_vec;
  int n_err;

  alu_iter_shifter #(.W(W), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data_in   (data_in),
    .amt       (amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .carry_out (carry_out),
    .zero      (zero),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {err, carry, data} computed directly from the operation's meaning
  function automatic logic [W+1:0] model(input logic [2:0] o, input logic [W-1:0] d, input int a);
    logic [63:0] m;
    logic [63:0] x;
    logic [63:0] r;
    logic        c;
    int          k;
    m = (64'd1 << W) - 64'd1;
    x = 64'(d);
    r = x;
    c = 1'b0;
    if (o > 3'd4) return {1'b1, 1'b0, d};
    if (a == 0) return {2'b00, d};
    case (o)
      3'd0: begin
        r = (a >= int'(W)) ? 64'd0 : (x >> a);
        c = (a > int'(W)) ? 1'b0 : x[a-1];
      end
      3'd1: begin
        r = (a >= int'(W)) ? 64'd0 : ((x << a) & m);
        c = (a > int'(W)) ? 1'b0 : x[int'(W)-a];
      end
      3'd2: begin
        k = (a > int'(W)) ? int'(W) : a;
        r = x[W-1] ? ((x >> k) | (m & ~(m >> k))) : (x >> k);
        c = x[k-1];
      end
      3'd3: begin
        k = a % int'(W);
        r = (k == 0) ? x : (((x >> k) | (x << (int'(W) - k))) & m);
        c = r[W-1];
      end
      default: begin
        k = a % int'(W);
        r = (k == 0) ? x : (((x << k) | (x >> (int'(W) - k))) & m);
        c = r[0];
      end
    endcase
    return {1'b0, c, r[W-1:0]};
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] d, input logic [SW-1:0] a,
                       input int hold);
    logic [W+1:0] e;
    int           cyc;
    int           lat;
    e   = model(o, d, int'(a));
    lat = (o > 3'd4) ? 1 : int'(a) + 1;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    op        = o;
    data_in   = d;
    amt       = a;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = W'($urandom);
    op       = 3'($urandom);
    amt      = SW'($urandom);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (out_valid || cyc > 64) break;
      check("busy_in_ready", 64'(in_ready), 64'd0);
    end
    check("latency", 64'(cyc), 64'(lat));
    check("data_out", 64'(data_out), 64'(e[W-1:0]));
    check("carry_out", 64'(carry_out), 64'(e[W]));
    check("zero", 64'(zero), 64'(e[W-1:0] == '0));
    check("err", 64'(err), 64'(e[W+1]));
    check("done_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      data_in  = W'($urandom);
      op       = 3'($urandom_range(0, 4));
      amt      = SW'($urandom);
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_data", 64'({err, carry_out, data_out}), 64'(e));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_in_ready", 64'(in_ready), 64'd1);
    check("post_hs_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'd0;
    data_in   = '0;
    amt       = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outs", 64'({err, zero, carry_out, data_out}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3'd4, 21'h100001, 5'd1, 0);
    do_op(3'd2, 21'h100000, 5'd4, 0);
    do_op(3'd0, 21'h100000, 5'd4, 0);
    do_op(3'd1, 21'h1FFFFF, 5'd25, 0);
    do_op(3'd3, 21'h0ABCDE, 5'd21, 0);
    do_op(3'd0, 21'h012345, 5'd0, 0);
    do_op(3'd6, 21'h0F0F0F, 5'd9, 0);
    do_op(3'd3, 21'h000001, 5'd3, 5);
    do_op(3'd2, 21'h1A5A5A, 5'd31, 2);

    // Reset in the middle of a long LSL
    @(negedge clk);
    in_valid = 1'b1;
    op       = 3'd1;
    data_in  = 21'h1FFFFF;
    amt      = 5'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("mid_run_busy", 64'({out_valid, in_ready}), 64'd0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_outs", 64'({err, zero, carry_out, data_out}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd3, 21'h0ABCDE, 5'd2, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      o = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      do_op(o, W'($urandom), SW'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
